// File: rtl/fabric_arbiter_mxn_ot_if.sv
// ============================================================================
// fabric_if : fabric request/response bus plus shared fabric constants
// Rev 1.0
// ============================================================================
`default_nettype none

package carbon_arch_pkg;
  localparam int          CARBON_FABRIC_ATTR_WIDTH_BITS = 4;
  localparam logic [7:0]  CARBON_FABRIC_RESP_OKAY       = 8'h00;
  localparam logic [7:0]  CARBON_FABRIC_RESP_DECODE_ERR = 8'h02;
endpackage

interface fabric_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int OP_W   = 8,
  parameter int SIZE_W = 3,
  parameter int CODE_W = 8,
  parameter int ATTR_W = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [ID_W-1:0]   req_id;
  logic [OP_W-1:0]   req_op;
  logic [SIZE_W-1:0] req_size;
  logic [ATTR_W-1:0] req_attr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ID_W-1:0]   rsp_id;
  logic [CODE_W-1:0] rsp_code;

  modport master (
    output req_valid, req_addr, req_wdata, req_id, req_op, req_size, req_attr,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_id, rsp_code,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_id, req_op, req_size, req_attr,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_id, rsp_code,
    input  rsp_ready
  );
endinterface

`default_nettype wire

// File: rtl/fabric_arbiter_mxn_ot.sv
// ============================================================================
// fabric_arbiter_mxn_ot : M-to-N fabric arbiter with in-order outstanding tracking
// Rev 1.0
// ============================================================================
`default_nettype none

module fabric_arbiter_mxn_ot #(
  parameter int M             = 2,
  parameter int N             = 1,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int ID_W          = 4,
  parameter int OP_W          = 8,
  parameter int SIZE_W        = 3,
  parameter int CODE_W        = 8,
  parameter int ATTR_W        = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
  parameter int HAS_DEFAULT   = 1,
  parameter int DEFAULT_SLAVE = 0,
  parameter logic [N-1:0][ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [N-1:0][ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int ARB_MODE      = 0,
  parameter int SLAVE_OT      = 4,
  parameter int MASTER_OT     = 4,
  localparam int SCW          = $clog2(SLAVE_OT + 1),
  localparam int MCW          = $clog2(MASTER_OT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fabric_if.slave              masters [M],
  fabric_if.master             slaves  [N],
  output logic [N*SCW-1:0]     slave_ot_cnt,
  output logic [M*MCW-1:0]     master_ot_cnt
);

  localparam int MIW = (M > 1) ? $clog2(M) : 1;
  localparam int SIW = (N > 1) ? $clog2(N) : 1;
  localparam int PW  = (SLAVE_OT > 1) ? $clog2(SLAVE_OT) : 1;

  // flattened copies of the interface arrays so they can be indexed at run time
  logic              m_req_valid [M];
  logic [ADDR_W-1:0] m_req_addr  [M];
  logic [DATA_W-1:0] m_req_wdata [M];
  logic [ID_W-1:0]   m_req_id    [M];
  logic [OP_W-1:0]   m_req_op    [M];
  logic [SIZE_W-1:0] m_req_size  [M];
  logic [ATTR_W-1:0] m_req_attr  [M];
  logic              m_rsp_ready [M];
  logic              m_req_ready [M];
  logic              m_rsp_valid [M];
  logic [DATA_W-1:0] m_rsp_rdata [M];
  logic [ID_W-1:0]   m_rsp_id    [M];
  logic [CODE_W-1:0] m_rsp_code  [M];

  logic              s_req_ready [N];
  logic              s_rsp_valid [N];
  logic [DATA_W-1:0] s_rsp_rdata [N];
  logic [ID_W-1:0]   s_rsp_id    [N];
  logic [CODE_W-1:0] s_rsp_code  [N];
  logic              s_rsp_ready [N];

  logic [SCW-1:0]    scnt_q   [N], scnt_d   [N];
  logic [MCW-1:0]    mcnt_q   [M], mcnt_d   [M];
  logic [SIW-1:0]    tgt_q    [M], tgt_d    [M];
  logic              lock_v_q [N], lock_v_d [N];
  logic [MIW-1:0]    lock_w_q [N], lock_w_d [N];
  logic [MIW-1:0]    rr_q     [N], rr_d     [N];
  logic [MIW-1:0]    fifo_q   [N][SLAVE_OT], fifo_d [N][SLAVE_OT];
  logic [PW-1:0]     wptr_q   [N], wptr_d   [N];
  logic [PW-1:0]     rptr_q   [N], rptr_d   [N];
  logic              err_q    [M], err_d    [M];
  logic [ID_W-1:0]   err_id_q [M], err_id_d [M];

  logic              dec_ok  [M];
  logic [SIW-1:0]    dec_idx [M];
  logic              m_elig  [M];
  logic              err_acc [M];
  logic              m_inc   [M];
  logic              m_dec   [M];
  logic [SIW-1:0]    m_inc_s [M];
  logic              gnt     [N];
  logic [MIW-1:0]    win     [N];
  logic              acc     [N];
  logic              hs      [N];
  logic              s_busy  [N];
  logic [MIW-1:0]    head    [N];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SLAVE_OT - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < M; i++) begin : g_mport
    assign m_req_valid[i] = masters[i].req_valid;
    assign m_req_addr[i]  = masters[i].req_addr;
    assign m_req_wdata[i] = masters[i].req_wdata;
    assign m_req_id[i]    = masters[i].req_id;
    assign m_req_op[i]    = masters[i].req_op;
    assign m_req_size[i]  = masters[i].req_size;
    assign m_req_attr[i]  = masters[i].req_attr;
    assign m_rsp_ready[i] = masters[i].rsp_ready;
    assign masters[i].req_ready = m_req_ready[i];
    assign masters[i].rsp_valid = m_rsp_valid[i];
    assign masters[i].rsp_rdata = m_rsp_rdata[i];
    assign masters[i].rsp_id    = m_rsp_id[i];
    assign masters[i].rsp_code  = m_rsp_code[i];
    assign master_ot_cnt[i*MCW +: MCW] = mcnt_q[i];
  end

  for (genvar j = 0; j < N; j++) begin : g_sport
    assign slaves[j].req_valid = gnt[j];
    assign slaves[j].req_addr  = gnt[j] ? m_req_addr[win[j]]  : '0;
    assign slaves[j].req_wdata = gnt[j] ? m_req_wdata[win[j]] : '0;
    assign slaves[j].req_id    = gnt[j] ? m_req_id[win[j]]    : '0;
    assign slaves[j].req_op    = gnt[j] ? m_req_op[win[j]]    : '0;
    assign slaves[j].req_size  = gnt[j] ? m_req_size[win[j]]  : '0;
    assign slaves[j].req_attr  = gnt[j] ? m_req_attr[win[j]]  : '0;
    assign slaves[j].rsp_ready = s_rsp_ready[j];
    assign s_req_ready[j] = slaves[j].req_ready;
    assign s_rsp_valid[j] = slaves[j].rsp_valid;
    assign s_rsp_rdata[j] = slaves[j].rsp_rdata;
    assign s_rsp_id[j]    = slaves[j].rsp_id;
    assign s_rsp_code[j]  = slaves[j].rsp_code;
    assign slave_ot_cnt[j*SCW +: SCW] = scnt_q[j];
  end

  // lowest-index matching window wins; everything is gated by rst_n so outputs idle in reset
  always_comb begin
    for (int m = 0; m < M; m++) begin
      logic hit;
      hit        = 1'b0;
      dec_idx[m] = SIW'(DEFAULT_SLAVE);
      for (int s = N - 1; s >= 0; s--) begin
        if ((m_req_addr[m] & SLAVE_MASK[s]) == SLAVE_BASE[s]) begin
          hit        = 1'b1;
          dec_idx[m] = SIW'(s);
        end
      end
      dec_ok[m]  = hit || (HAS_DEFAULT != 0);
      m_elig[m]  = rst_n && m_req_valid[m] && dec_ok[m] && !err_q[m] &&
                   (mcnt_q[m] < MCW'(MASTER_OT)) &&
                   ((mcnt_q[m] == '0) || (dec_idx[m] == tgt_q[m]));
      err_acc[m] = rst_n && m_req_valid[m] && !dec_ok[m] && !err_q[m] &&
                   (mcnt_q[m] == '0);
    end
  end

  always_comb begin
    for (int s = 0; s < N; s++) begin
      logic found;
      int   idx;
      found  = 1'b0;
      idx    = 0;
      gnt[s] = 1'b0;
      win[s] = '0;
      if (lock_v_q[s]) begin
        gnt[s] = rst_n;
        win[s] = lock_w_q[s];
      end else if (scnt_q[s] < SCW'(SLAVE_OT)) begin
        if (ARB_MODE == 1) begin
          for (int k = M - 1; k >= 0; k--) begin
            if (m_elig[k] && (dec_idx[k] == SIW'(s))) begin
              gnt[s] = 1'b1;
              win[s] = MIW'(k);
            end
          end
        end else begin
          for (int k = 0; k < M; k++) begin
            idx = (int'(rr_q[s]) + k) % M;
            if (!found && m_elig[idx] && (dec_idx[idx] == SIW'(s))) begin
              found  = 1'b1;
              gnt[s] = 1'b1;
              win[s] = MIW'(idx);
            end
          end
        end
      end
      acc[s]         = gnt[s] && s_req_ready[s];
      s_busy[s]      = rst_n && (scnt_q[s] != '0);
      head[s]        = fifo_q[s][rptr_q[s]];
      s_rsp_ready[s] = s_busy[s] && m_rsp_ready[head[s]];
      hs[s]          = s_rsp_valid[s] && s_rsp_ready[s];
    end
  end

  always_comb begin
    for (int m = 0; m < M; m++) begin
      m_req_ready[m] = err_acc[m];
      m_inc[m]       = 1'b0;
      m_inc_s[m]     = '0;
      m_dec[m]       = 1'b0;
      m_rsp_valid[m] = 1'b0;
      m_rsp_rdata[m] = '0;
      m_rsp_id[m]    = '0;
      m_rsp_code[m]  = '0;
      for (int s = 0; s < N; s++) begin
        if (acc[s] && (win[s] == MIW'(m))) begin
          m_req_ready[m] = 1'b1;
          m_inc[m]       = 1'b1;
          m_inc_s[m]     = SIW'(s);
        end
        if (s_busy[s] && (head[s] == MIW'(m))) begin
          m_rsp_valid[m] = s_rsp_valid[s];
          m_rsp_rdata[m] = s_rsp_rdata[s];
          m_rsp_id[m]    = s_rsp_id[s];
          m_rsp_code[m]  = s_rsp_code[s];
          m_dec[m]       = hs[s];
        end
      end
      if (err_q[m]) begin
        m_rsp_valid[m] = 1'b1;
        m_rsp_rdata[m] = '0;
        m_rsp_id[m]    = err_id_q[m];
        m_rsp_code[m]  = CODE_W'(carbon_arch_pkg::CARBON_FABRIC_RESP_DECODE_ERR);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < N; s++) begin
      scnt_d[s]   = scnt_q[s];
      lock_v_d[s] = lock_v_q[s];
      lock_w_d[s] = lock_w_q[s];
      rr_d[s]     = rr_q[s];
      wptr_d[s]   = wptr_q[s];
      rptr_d[s]   = rptr_q[s];
      for (int e = 0; e < SLAVE_OT; e++) fifo_d[s][e] = fifo_q[s][e];
      if (acc[s] && !hs[s])      scnt_d[s] = scnt_q[s] + 1'b1;
      else if (!acc[s] && hs[s]) scnt_d[s] = scnt_q[s] - 1'b1;
      if (acc[s]) begin
        fifo_d[s][wptr_q[s]] = win[s];
        wptr_d[s]   = ptr_inc(wptr_q[s]);
        lock_v_d[s] = 1'b0;
        if (ARB_MODE == 0) rr_d[s] = MIW'((int'(win[s]) + 1) % M);
      end else if (gnt[s] && !lock_v_q[s]) begin
        lock_v_d[s] = 1'b1;
        lock_w_d[s] = win[s];
      end
      if (hs[s]) rptr_d[s] = ptr_inc(rptr_q[s]);
    end
    for (int m = 0; m < M; m++) begin
      mcnt_d[m]   = mcnt_q[m];
      tgt_d[m]    = tgt_q[m];
      err_d[m]    = err_q[m];
      err_id_d[m] = err_id_q[m];
      if (m_inc[m] && !m_dec[m])      mcnt_d[m] = mcnt_q[m] + 1'b1;
      else if (!m_inc[m] && m_dec[m]) mcnt_d[m] = mcnt_q[m] - 1'b1;
      if (m_inc[m]) tgt_d[m] = m_inc_s[m];
      if (err_acc[m]) begin
        err_d[m]    = 1'b1;
        err_id_d[m] = m_req_id[m];
      end else if (err_q[m] && m_rsp_ready[m]) begin
        err_d[m] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N; s++) begin
        scnt_q[s]   <= '0;
        lock_v_q[s] <= 1'b0;
        lock_w_q[s] <= '0;
        rr_q[s]     <= '0;
        wptr_q[s]   <= '0;
        rptr_q[s]   <= '0;
        for (int e = 0; e < SLAVE_OT; e++) fifo_q[s][e] <= '0;
      end
      for (int m = 0; m < M; m++) begin
        mcnt_q[m]   <= '0;
        tgt_q[m]    <= '0;
        err_q[m]    <= 1'b0;
        err_id_q[m] <= '0;
      end
    end else begin
      for (int s = 0; s < N; s++) begin
        scnt_q[s]   <= scnt_d[s];
        lock_v_q[s] <= lock_v_d[s];
        lock_w_q[s] <= lock_w_d[s];
        rr_q[s]     <= rr_d[s];
        wptr_q[s]   <= wptr_d[s];
        rptr_q[s]   <= rptr_d[s];
        for (int e = 0; e < SLAVE_OT; e++) fifo_q[s][e] <= fifo_d[s][e];
      end
      for (int m = 0; m < M; m++) begin
        mcnt_q[m]   <= mcnt_d[m];
        tgt_q[m]    <= tgt_d[m];
        err_q[m]    <= err_d[m];
        err_id_q[m] <= err_id_d[m];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fabric_arbiter_mxn_ot.sv
// ============================================================================
// tb_fabric_arbiter_mxn_ot : directed bench for round-robin and fixed-priority arbiters
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fabric_arbiter_mxn_ot;

  localparam logic [0:0][31:0] BASE = '0;
  localparam logic [0:0][31:0] MASK = {32'hF000_0000};
  localparam logic [7:0]       DERR = 8'h02;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] r_scnt, f_scnt;
  logic [5:0] r_mcnt, f_mcnt;
  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fabric_if rm [2] ();
  fabric_if rs [1] ();
  fabric_if fm [2] ();
  fabric_if fs [1] ();

  fabric_arbiter_mxn_ot #(.M(2), .N(1), .HAS_DEFAULT(0), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                          .ARB_MODE(0), .SLAVE_OT(4), .MASTER_OT(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .masters(rm), .slaves(rs),
    .slave_ot_cnt(r_scnt), .master_ot_cnt(r_mcnt));

  fabric_arbiter_mxn_ot #(.M(2), .N(1), .HAS_DEFAULT(0), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
                          .ARB_MODE(1), .SLAVE_OT(4), .MASTER_OT(4)) u_fp (
    .clk(clk), .rst_n(rst_n), .masters(fm), .slaves(fs),
    .slave_ot_cnt(f_scnt), .master_ot_cnt(f_mcnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rreq(input logic v0, input logic [31:0] a0, input logic [3:0] i0,
                      input logic v1, input logic [31:0] a1, input logic [3:0] i1);
    rm[0].req_valid = v0; rm[0].req_addr = a0; rm[0].req_id = i0;
    rm[1].req_valid = v1; rm[1].req_addr = a1; rm[1].req_id = i1;
  endtask

  task automatic freq(input logic v0, input logic v1);
    fm[0].req_valid = v0; fm[0].req_addr = 32'h100; fm[0].req_id = 4'd1;
    fm[1].req_valid = v1; fm[1].req_addr = 32'h200; fm[1].req_id = 4'd2;
  endtask

  task automatic rsrsp(input logic v, input logic [31:0] d, input logic [3:0] id);
    rs[0].rsp_valid = v; rs[0].rsp_rdata = d; rs[0].rsp_id = id; rs[0].rsp_code = 8'h00;
  endtask

  initial begin
    rreq(1'b1, 32'h100, 4'd1, 1'b0, 32'h0, 4'd0);
    rm[0].req_wdata = '0; rm[0].req_op = '0; rm[0].req_size = '0; rm[0].req_attr = '0;
    rm[1].req_wdata = '0; rm[1].req_op = '0; rm[1].req_size = '0; rm[1].req_attr = '0;
    rm[0].rsp_ready = 1'b1; rm[1].rsp_ready = 1'b1;
    rs[0].req_ready = 1'b1; rsrsp(1'b1, 32'h0, 4'd0);
    freq(1'b0, 1'b0);
    fm[0].req_wdata = '0; fm[0].req_op = '0; fm[0].req_size = '0; fm[0].req_attr = '0;
    fm[1].req_wdata = '0; fm[1].req_op = '0; fm[1].req_size = '0; fm[1].req_attr = '0;
    fm[0].rsp_ready = 1'b1; fm[1].rsp_ready = 1'b1;
    fs[0].req_ready = 1'b1; fs[0].rsp_valid = 1'b0; fs[0].rsp_rdata = '0;
    fs[0].rsp_id = '0; fs[0].rsp_code = '0;

    // reset holds outputs idle even with a live request and response
    #3;
    chk("rst_req_valid", rs[0].req_valid, 1'b0);
    chk("rst_req_ready", rm[0].req_ready, 1'b0);
    chk("rst_rsp_ready", rs[0].rsp_ready, 1'b0);
    chk("rst_req_addr", rs[0].req_addr, 32'h0);
    chk("rst_scnt", r_scnt, 3'd0);
    chk("rst_mcnt", r_mcnt, 6'h00);
    tick(); tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    rst_n = 1'b1;

    // round-robin alternation
    rreq(1'b1, 32'h100, 4'd1, 1'b1, 32'h200, 4'd2);
    #1;
    chk("rr_c1_addr", rs[0].req_addr, 32'h100);
    chk("rr_c1_m0rdy", rm[0].req_ready, 1'b1);
    chk("rr_c1_m1rdy", rm[1].req_ready, 1'b0);
    tick();
    chk("rr_c2_addr", rs[0].req_addr, 32'h200);
    chk("rr_c2_m1rdy", rm[1].req_ready, 1'b1);
    tick();
    chk("rr_c3_addr", rs[0].req_addr, 32'h100);
    tick();
    chk("rr_c4_addr", rs[0].req_addr, 32'h200);
    tick();
    chk("rr_full_scnt", r_scnt, 3'd4);
    chk("rr_full_mcnt", r_mcnt, {3'd2, 3'd2});
    chk("rr_full_reqv", rs[0].req_valid, 1'b0);
    rreq(1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    rsrsp(1'b1, 32'hA0, 4'd1);
    #1;
    chk("rr_r1_m0v", rm[0].rsp_valid, 1'b1);
    chk("rr_r1_m1v", rm[1].rsp_valid, 1'b0);
    chk("rr_r1_data", rm[0].rsp_rdata, 32'hA0);
    chk("rr_r1_srdy", rs[0].rsp_ready, 1'b1);
    tick();
    rsrsp(1'b1, 32'hA1, 4'd2);
    #1;
    chk("rr_r2_m1v", rm[1].rsp_valid, 1'b1);
    chk("rr_r2_m0v", rm[0].rsp_valid, 1'b0);
    chk("rr_r2_id", rm[1].rsp_id, 4'd2);
    tick(); tick(); tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    chk("rr_drain_scnt", r_scnt, 3'd0);
    chk("rr_drain_mcnt", r_mcnt, 6'h00);

    // lock under backpressure: m1 granted first, m0 joins but cannot steal
    rs[0].req_ready = 1'b0;
    rreq(1'b0, 32'h100, 4'd1, 1'b1, 32'h400, 4'd3);
    #1;
    chk("lk_c1_addr", rs[0].req_addr, 32'h400);
    tick();
    rreq(1'b1, 32'h100, 4'd1, 1'b1, 32'h400, 4'd3);
    #1;
    chk("lk_c2_addr", rs[0].req_addr, 32'h400);
    chk("lk_c2_m0rdy", rm[0].req_ready, 1'b0);
    tick();
    chk("lk_c3_id", rs[0].req_id, 4'd3);
    tick();
    rs[0].req_ready = 1'b1;
    #1;
    chk("lk_c4_m1rdy", rm[1].req_ready, 1'b1);
    chk("lk_c4_m0rdy", rm[0].req_ready, 1'b0);
    tick();
    rreq(1'b1, 32'h100, 4'd1, 1'b0, 32'h0, 4'd0);
    #1;
    chk("lk_c5_addr", rs[0].req_addr, 32'h100);
    chk("lk_c5_m0rdy", rm[0].req_ready, 1'b1);
    tick();
    rreq(1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    rsrsp(1'b1, 32'hB0, 4'd3);
    #1;
    chk("lk_r1_m1v", rm[1].rsp_valid, 1'b1);
    tick();
    chk("lk_r2_m0v", rm[0].rsp_valid, 1'b1);
    tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    chk("lk_drain_scnt", r_scnt, 3'd0);

    // slave outstanding limit
    rreq(1'b1, 32'h300, 4'd4, 1'b0, 32'h0, 4'd0);
    tick(); tick(); tick(); tick();
    chk("ot_5th_rdy", rm[0].req_ready, 1'b0);
    chk("ot_scnt4", r_scnt, 3'd4);
    rsrsp(1'b1, 32'hC0, 4'd4);
    #1;
    chk("ot_rsp_srdy", rs[0].rsp_ready, 1'b1);
    tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    #1;
    chk("ot_scnt3", r_scnt, 3'd3);
    chk("ot_5th_acc", rm[0].req_ready, 1'b1);
    tick();
    chk("ot_scnt4b", r_scnt, 3'd4);
    rreq(1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    rsrsp(1'b1, 32'hC1, 4'd4);
    tick(); tick(); tick(); tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    chk("ot_drain_mcnt", r_mcnt, 6'h00);

    // a response with nothing outstanding is refused
    rsrsp(1'b1, 32'hDD, 4'd9);
    #1;
    chk("empty_srdy", rs[0].rsp_ready, 1'b0);
    chk("empty_m0v", rm[0].rsp_valid, 1'b0);
    tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    chk("empty_scnt", r_scnt, 3'd0);

    // decode error with nothing outstanding
    rreq(1'b1, 32'h1000_0000, 4'd5, 1'b0, 32'h0, 4'd0);
    rm[0].rsp_ready = 1'b0;
    #1;
    chk("de_rdy", rm[0].req_ready, 1'b1);
    chk("de_no_route", rs[0].req_valid, 1'b0);
    tick();
    rreq(1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("de_rspv", rm[0].rsp_valid, 1'b1);
    chk("de_code", rm[0].rsp_code, DERR);
    chk("de_id", rm[0].rsp_id, 4'd5);
    chk("de_data", rm[0].rsp_rdata, 32'h0);
    tick();
    chk("de_hold1", rm[0].rsp_valid, 1'b1);
    tick();
    chk("de_hold2_id", rm[0].rsp_id, 4'd5);
    rm[0].rsp_ready = 1'b1;
    tick();
    chk("de_clear", rm[0].rsp_valid, 1'b0);

    // decode error stalls behind outstanding traffic
    rreq(1'b1, 32'h500, 4'd7, 1'b0, 32'h0, 4'd0);
    tick(); tick();
    rreq(1'b1, 32'h1000_0000, 4'd6, 1'b0, 32'h0, 4'd0);
    #1;
    chk("des_mcnt2", r_mcnt, {3'd0, 3'd2});
    chk("des_stall", rm[0].req_ready, 1'b0);
    rsrsp(1'b1, 32'hE0, 4'd7);
    tick();
    chk("des_stall2", rm[0].req_ready, 1'b0);
    tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    #1;
    chk("des_go", rm[0].req_ready, 1'b1);
    tick();
    rreq(1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("des_id", rm[0].rsp_id, 4'd6);
    chk("des_code", rm[0].rsp_code, DERR);
    tick();
    chk("des_clear", rm[0].rsp_valid, 1'b0);

    // fixed priority: m0 always wins, accept+response keeps count steady
    freq(1'b1, 1'b1);
    fs[0].rsp_valid = 1'b1; fs[0].rsp_rdata = 32'hF0;
    #1;
    chk("fp_c1_addr", fs[0].req_addr, 32'h100);
    chk("fp_c1_m1rdy", fm[1].req_ready, 1'b0);
    tick();
    chk("fp_c2_addr", fs[0].req_addr, 32'h100);
    tick();
    chk("fp_c3_m0rdy", fm[0].req_ready, 1'b1);
    chk("fp_c3_m1rdy", fm[1].req_ready, 1'b0);
    chk("fp_steady", f_scnt, 3'd1);
    tick();
    freq(1'b0, 1'b1);
    #1;
    chk("fp_m1_addr", fs[0].req_addr, 32'h200);
    chk("fp_m1_rdy", fm[1].req_ready, 1'b1);
    tick();
    freq(1'b0, 1'b0);
    chk("fp_m1_rspv", fm[1].rsp_valid, 1'b1);
    tick();
    fs[0].rsp_valid = 1'b0;
    chk("fp_drain", f_scnt, 3'd0);

    // asynchronous reset mid-burst
    rreq(1'b1, 32'h600, 4'd8, 1'b0, 32'h0, 4'd0);
    tick(); tick(); tick();
    chk("rb_scnt3", r_scnt, 3'd3);
    rst_n = 1'b0;
    rsrsp(1'b1, 32'h1, 4'd8);
    #1;
    chk("rb_scnt0", r_scnt, 3'd0);
    chk("rb_mcnt0", r_mcnt, 6'h00);
    chk("rb_reqv", rs[0].req_valid, 1'b0);
    chk("rb_rsprdy", rs[0].rsp_ready, 1'b0);
    tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    rst_n = 1'b1;
    #1;
    chk("rb_fresh_addr", rs[0].req_addr, 32'h600);
    chk("rb_fresh_rdy", rm[0].req_ready, 1'b1);
    tick();
    rreq(1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
    chk("rb_fresh_scnt", r_scnt, 3'd1);
    rsrsp(1'b1, 32'h2, 4'd8);
    tick();
    rsrsp(1'b0, 32'h0, 4'd0);
    chk("rb_end_scnt", r_scnt, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
